// File: rtl/col_parity_engine.sv
// col_parity_engine: streams every slice of a ROWS x COLS x DEPTH state
// memory once, writing back either the theta-updated slice (mode 0) or the
// slice's column parity (mode 1). Slice 0 uses the parity of slice DEPTH-1,
// fetched up front by the PRE/LOAD states.
module col_parity_engine #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int DEPTH = 64,
    parameter int AW    = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [ROWS*COLS-1:0] rd_data,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [ROWS*COLS-1:0] wr_data,
    output logic                 busy,
    output logic                 done
);

    localparam int W = ROWS * COLS;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_z;
    logic [AW-1:0]   w_z_nxt;
    logic [COLS-1:0] r_prev_par;
    logic [COLS-1:0] w_prev_nxt;
    logic            r_mode;
    logic            w_mode_nxt;

    logic [COLS-1:0] w_par;
    logic [W-1:0]    w_theta;
    logic [W-1:0]    w_par_line;

    // Column parity of the line currently presented on rd_data
    always_comb begin
        w_par = '0;
        for (int unsigned y = 0; y < ROWS; y++) begin
            for (int unsigned x = 0; x < COLS; x++) begin
                w_par[x] = w_par[x] ^ rd_data[y*COLS + x];
            end
        end
    end

    // Theta update: own left-neighbour column parity plus previous slice's right-neighbour parity
    always_comb begin
        w_theta = '0;
        for (int unsigned y = 0; y < ROWS; y++) begin
            for (int unsigned x = 0; x < COLS; x++) begin
                w_theta[y*COLS + x] = rd_data[y*COLS + x]
                                    ^ w_par[(x + COLS - 1) % COLS]
                                    ^ r_prev_par[(x + 1) % COLS];
            end
        end
    end

    // Parity-only line: column parity in the low bits, zero elsewhere
    always_comb begin
        w_par_line             = '0;
        w_par_line[COLS-1:0]   = w_par;
    end

    // State, slice counter, previous parity and latched mode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_z        <= '0;
            r_prev_par <= '0;
            r_mode     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_z        <= w_z_nxt;
            r_prev_par <= w_prev_nxt;
            r_mode     <= w_mode_nxt;
        end
    end

    // Next-state decode and memory/handshake strobes
    always_comb begin
        w_state_nxt = r_state;
        w_z_nxt     = r_z;
        w_prev_nxt  = r_prev_par;
        w_mode_nxt  = r_mode;
        rd_en       = 1'b0;
        rd_addr     = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mode_nxt  = mode;
                    w_state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                busy        = 1'b1;
                rd_en       = 1'b1;
                rd_addr     = LAST;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy        = 1'b1;
                rd_en       = 1'b1;
                rd_addr     = '0;
                w_prev_nxt  = w_par;
                w_z_nxt     = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy       = 1'b1;
                wr_en      = 1'b1;
                wr_addr    = r_z;
                wr_data    = r_mode ? w_par_line : w_theta;
                w_prev_nxt = w_par;
                if (r_z != LAST) begin
                    rd_en   = 1'b1;
                    rd_addr = r_z + AW'(1);
                    w_z_nxt = r_z + AW'(1);
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_col_parity_engine.sv
// tb_col_parity_engine: scoreboard bench for col_parity_engine. Two DUTs:
// DEPTH=64 (directed and reset cases) and DEPTH=8 (random vs. model).
// Cycle numbering: the active edge that accepts start (edge k) opens cycle
// k+1, so done in cycle k+DEPTH+3 is seen after edge k+DEPTH+2.
module tb_col_parity_engine;

    typedef struct {
        logic [6:0]  addr;
        logic [24:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        start64, start8;

    logic        rd_en64, wr_en64, busy64, done64;
    logic [6:0]  rd_addr64, wr_addr64;
    logic [24:0] rd_data64, wr_data64;

    logic        rd_en8, wr_en8, busy8, done8;
    logic [2:0]  rd_addr8, wr_addr8;
    logic [24:0] rd_data8, wr_data8;

    logic [24:0] mem64 [64];
    logic [24:0] mem8  [8];

    exp_t q64[$];
    exp_t q8[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fw_cyc64, fw_cyc8;
    bit fw_seen64, fw_seen8;

    col_parity_engine #(.ROWS(5), .COLS(5), .DEPTH(64), .AW(7)) u_dut64 (
        .clk(clk), .rst(rst), .start(start64), .mode(mode),
        .rd_en(rd_en64), .rd_addr(rd_addr64), .rd_data(rd_data64),
        .wr_en(wr_en64), .wr_addr(wr_addr64), .wr_data(wr_data64),
        .busy(busy64), .done(done64)
    );

    col_parity_engine #(.ROWS(5), .COLS(5), .DEPTH(8), .AW(3)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode),
        .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_data8),
        .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory models
    always @(posedge clk) begin
        if (rd_en64) rd_data64 <= mem64[rd_addr64];
        if (rd_en8)  rd_data8  <= mem8[rd_addr8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write monitors / scoreboard pop
    always @(negedge clk) begin
        exp_t e;
        if (rd_en64 && wr_en64) check("rw_same_slice64", 32'(rd_addr64 == wr_addr64), 0);
        if (wr_en64) begin
            if (!fw_seen64) begin fw_seen64 = 1; fw_cyc64 = cyc; end
            if (q64.size() == 0) check("spurious_wr64", 32'(wr_en64), 0);
            else begin
                e = q64.pop_front();
                check("wr_addr64", 32'(wr_addr64), 32'(e.addr));
                check("wr_data64", 32'(wr_data64), 32'(e.data));
            end
        end
        if (rd_en8 && wr_en8) check("rw_same_slice8", 32'(rd_addr8 == wr_addr8), 0);
        if (wr_en8) begin
            if (!fw_seen8) begin fw_seen8 = 1; fw_cyc8 = cyc; end
            if (q8.size() == 0) check("spurious_wr8", 32'(wr_en8), 0);
            else begin
                e = q8.pop_front();
                check("wr_addr8", 32'(wr_addr8), 32'(e.addr));
                check("wr_data8", 32'(wr_data8), 32'(e.data));
            end
        end
    end

    function automatic logic [4:0] col_par(input logic [24:0] v);
        logic [4:0] p = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                p[x] ^= v[y*5 + x];
        return p;
    endfunction

    function automatic logic [24:0] theta(input logic [24:0] cur, input logic [4:0] prv);
        logic [24:0] o;
        logic [4:0]  pc = col_par(cur);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                o[y*5 + x] = cur[y*5 + x] ^ pc[(x + 4) % 5] ^ prv[(x + 1) % 5];
        return o;
    endfunction

    task automatic push_exp(input bit sel, input int a, input logic [24:0] d);
        exp_t e;
        e.addr = 7'(a);
        e.data = d;
        if (sel) q8.push_back(e); else q64.push_back(e);
    endtask

    // Reference model: expected writes for the current memory image
    task automatic push_model(input bit sel, input bit md);
        int d = sel ? 8 : 64;
        logic [24:0] cur, prv;
        for (int z = 0; z < d; z++) begin
            cur = sel ? mem8[z] : mem64[z];
            prv = sel ? mem8[(z + d - 1) % d] : mem64[(z + d - 1) % d];
            push_exp(sel, z, md ? {20'b0, col_par(cur)} : theta(cur, col_par(prv)));
        end
    endtask

    task automatic run(input bit sel, input bit md, input int depth);
        int k;
        bit got = 0;
        fw_seen64 = 0;
        fw_seen8  = 0;
        @(negedge clk);
        mode = md;
        if (sel) start8 = 1'b1; else start64 = 1'b1;
        @(posedge clk);
        #1;
        k       = cyc;
        start64 = 1'b0;
        start8  = 1'b0;
        mode    = ~md;  // latched mode must hold for the whole run
        for (int i = 0; i < depth + 20 && !got; i++) begin
            @(negedge clk);
            if (sel ? done8 : done64) begin
                got = 1;
                check("done_latency", 32'(cyc - k), 32'(depth + 2));
                check("busy_in_done", 32'(sel ? busy8 : busy64), 0);
            end
        end
        check("done_seen", 32'(got), 1);
        check("first_wr_latency", 32'((sel ? fw_cyc8 : fw_cyc64) - k), 2);
        @(negedge clk);
        check("done_one_cycle", 32'(sel ? done8 : done64), 0);
        check("idle_rd_en", 32'(sel ? rd_en8 : rd_en64), 0);
        check("queue_drained", 32'(sel ? q8.size() : q64.size()), 0);
    endtask

    task automatic fill64(input logic [24:0] v);
        for (int i = 0; i < 64; i++) mem64[i] = v;
    endtask

    initial begin
        int k;
        rst     = 1'b0;
        start64 = 1'b0;
        start8  = 1'b0;
        mode    = 1'b0;
        fill64('0);
        for (int i = 0; i < 8; i++) mem8[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy64), 0);
        check("rst_done", 32'(done64), 0);
        check("rst_rd_en", 32'(rd_en64), 0);
        check("rst_wr_en", 32'(wr_en64), 0);
        check("rst_rd_addr", 32'(rd_addr64), 0);
        check("rst_wr_addr", 32'(wr_addr64), 0);
        check("rst_wr_data", 32'(wr_data64), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero memory, theta mode
        for (int z = 0; z < 64; z++) push_exp(0, z, 25'h0);
        run(0, 0, 64);

        // Single bit in slice 0
        mem64[0] = 25'h0000001;
        push_exp(0, 0, 25'h0210843);
        push_exp(0, 1, 25'h1084210);
        for (int z = 2; z < 64; z++) push_exp(0, z, 25'h0);
        run(0, 0, 64);

        // Single bit in slice 63: wrap-around into slice 0
        fill64('0);
        mem64[63] = 25'h0000001;
        push_exp(0, 0, 25'h1084210);
        for (int z = 1; z < 63; z++) push_exp(0, z, 25'h0);
        push_exp(0, 63, 25'h0210843);
        run(0, 0, 64);

        // Parity-only mode
        fill64('0);
        mem64[5] = 25'h1FFFFFF;
        mem64[6] = 25'h0000021;
        for (int z = 0; z < 64; z++) push_exp(0, z, (z == 5) ? 25'h000001F : 25'h0);
        run(0, 1, 64);

        // Random contents, both modes, against the model
        for (int i = 0; i < 64; i++) mem64[i] = 25'($urandom);
        push_model(0, 0);
        run(0, 0, 64);
        push_model(0, 1);
        run(0, 1, 64);

        // Reset mid-run with an ignored start while busy
        push_model(0, 0);
        fw_seen64 = 0;
        @(negedge clk);
        mode    = 1'b0;
        start64 = 1'b1;
        @(posedge clk);
        #1;
        k       = cyc;
        start64 = 1'b0;
        while (cyc < k + 4) @(negedge clk);
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        check("busy_mid_run", 32'(busy64), 1);
        while (cyc < k + 9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy64), 0);
        check("midrst_wr_en", 32'(wr_en64), 0);
        check("midrst_rd_en", 32'(rd_en64), 0);
        check("midrst_wr_data", 32'(wr_data64), 0);
        q64.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle", 32'(busy64), 0);
        push_model(0, 0);
        run(0, 0, 64);

        // DEPTH=8 instance, random contents
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) mem8[i] = 25'($urandom);
            push_model(1, r[0]);
            run(1, r[0], 8);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
